// File: rtl/mtimer_rd_irq_if.sv
// Peripheral bus for the readable machine timer: single-cycle req/we
// access, with ack and read data returned in the following cycle.
interface mtimer_rd_irq_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_in;
  logic              we_in;
  logic [ADDR_W-1:0] addr_in;
  logic [31:0]       wdata_in;
  logic [31:0]       rdata_out;
  logic              ack_out;

  modport master (output req_in, we_in, addr_in, wdata_in, input rdata_out, ack_out);
  modport slave  (input req_in, we_in, addr_in, wdata_in, output rdata_out, ack_out);
endinterface

// File: rtl/mtimer_rd_irq.sv
// Readable/writable 64-bit machine timer with prescaler and level interrupt.
// Optional MTIMER_HI_LATCH_EN: MTIME_LO reads latch mtime[63:32] for coherent HI reads.
module mtimer_rd_irq #(
  parameter logic [31:0] DIV_DEFAULT = 32'd1000,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic           clk_in,
  input  logic           reset_in,
  mtimer_rd_irq_if.slave bus,
  output logic           irq_out
);
  typedef enum logic [2:0] {
    R_MTIME_LO, R_MTIME_HI, R_CMP_LO, R_CMP_HI, R_CTRL, R_PRESCALE, R_RSV6, R_RSV7
  } reg_e;

  reg_e        sel;
  logic        wr, rd, tick;
  logic [63:0] mtime, mtimecmp;
  logic        en, irq_en;
  logic [31:0] prescale, pcnt, rd_mux;
`ifdef MTIMER_HI_LATCH_EN
  logic [31:0] shadow;
`endif

  logic unused_addr;
  assign unused_addr = ^{bus.addr_in[ADDR_W-1:5], bus.addr_in[1:0]};

  assign sel  = reg_e'(bus.addr_in[4:2]);
  assign wr   = bus.req_in & bus.we_in;
  assign rd   = bus.req_in & ~bus.we_in;
  assign tick = en && (pcnt == prescale);

  always_comb begin
    rd_mux = '0;
    unique case (sel)
      R_MTIME_LO: rd_mux = mtime[31:0];
`ifdef MTIMER_HI_LATCH_EN
      R_MTIME_HI: rd_mux = shadow;
`else
      R_MTIME_HI: rd_mux = mtime[63:32];
`endif
      R_CMP_LO:   rd_mux = mtimecmp[31:0];
      R_CMP_HI:   rd_mux = mtimecmp[63:32];
      R_CTRL:     rd_mux = {30'd0, irq_en, en};
      R_PRESCALE: rd_mux = prescale;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mtime         <= '0;
      mtimecmp      <= '1;
      en            <= 1'b1;
      irq_en        <= 1'b0;
      prescale      <= DIV_DEFAULT;
      pcnt          <= '0;
      bus.ack_out   <= 1'b0;
      bus.rdata_out <= '0;
      irq_out       <= 1'b0;
`ifdef MTIMER_HI_LATCH_EN
      shadow        <= '0;
`endif
    end else begin
      bus.ack_out   <= bus.req_in;
      bus.rdata_out <= rd ? rd_mux : '0;
      irq_out       <= irq_en && (mtime >= mtimecmp);

      if (en)   pcnt  <= tick ? '0 : pcnt + 32'd1;
      if (tick) mtime <= mtime + 64'd1;

`ifdef MTIMER_HI_LATCH_EN
      if (rd && sel == R_MTIME_LO) shadow <= mtime[63:32];
`endif

      // Full-width mtime writes override the tick increment; a colliding
      // tick has already cleared pcnt above.
      if (wr) begin
        unique case (sel)
          R_MTIME_LO: mtime <= {mtime[63:32], bus.wdata_in};
          R_MTIME_HI: begin
            mtime <= {bus.wdata_in, mtime[31:0]};
`ifdef MTIMER_HI_LATCH_EN
            shadow <= '0;
`endif
          end
          R_CMP_LO:   mtimecmp[31:0]  <= bus.wdata_in;
          R_CMP_HI:   mtimecmp[63:32] <= bus.wdata_in;
          R_CTRL: begin
            en     <= bus.wdata_in[0];
            irq_en <= bus.wdata_in[1];
          end
          R_PRESCALE: begin
            prescale <= bus.wdata_in;
            pcnt     <= '0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mtimer_rd_irq.sv
// Directed + randomized bench for mtimer_rd_irq against a cycle-level behavioural model.
module tb_mtimer_rd_irq;
  logic clk_in = 1'b0;
  logic reset_in;
  logic irq_out;

  mtimer_rd_irq_if #(.ADDR_W(32)) bus ();

  mtimer_rd_irq #(.DIV_DEFAULT(32'd1000), .ADDR_W(32)) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .bus     (bus.slave),
    .irq_out (irq_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [63:0] m_time, m_cmp;
  logic        m_en, m_ien;
  logic [31:0] m_pre, m_pcnt, m_sh;
  logic        e_ack, e_irq;
  logic [31:0] e_rd, last_rd, frozen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return m_time[31:0];
`ifdef MTIMER_HI_LATCH_EN
      3'd1: return m_sh;
`else
      3'd1: return m_time[63:32];
`endif
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {30'd0, m_ien, m_en};
      3'd5: return m_pre;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge given the inputs present before it.
  task automatic model_step(input logic rst, input logic req, input logic we,
                            input logic [2:0] a, input logic [31:0] wd);
    logic        due;
    logic [63:0] n_time;
    logic [31:0] n_pcnt;
    if (rst) begin
      m_time = 64'd0; m_cmp = '1; m_en = 1'b1; m_ien = 1'b0;
      m_pre = 32'd1000; m_pcnt = 32'd0; m_sh = 32'd0;
      e_ack = 1'b0; e_rd = 32'd0; e_irq = 1'b0;
      return;
    end
    e_ack = req;
    e_rd  = (req && !we) ? model_read(a) : 32'd0;
    e_irq = m_ien && (m_time >= m_cmp);
    due    = m_en && (m_pcnt == m_pre);
    n_time = due ? m_time + 64'd1 : m_time;
    n_pcnt = !m_en ? m_pcnt : (due ? 32'd0 : m_pcnt + 32'd1);
    if (req && !we && a == 3'd0) m_sh = m_time[63:32];
    if (req && we) begin
      case (a)
        3'd0: n_time = {m_time[63:32], wd};
        3'd1: begin n_time = {wd, m_time[31:0]}; m_sh = 32'd0; end
        3'd2: m_cmp[31:0]  = wd;
        3'd3: m_cmp[63:32] = wd;
        3'd4: begin m_en = wd[0]; m_ien = wd[1]; end
        3'd5: begin m_pre = wd; n_pcnt = 32'd0; end
        default: ;
      endcase
    end
    m_time = n_time;
    m_pcnt = n_pcnt;
  endtask

  task automatic cyc(input logic rst, input logic req, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd);
    reset_in     = rst;
    bus.req_in   = req;
    bus.we_in    = we;
    bus.addr_in  = addr;
    bus.wdata_in = wd;
    @(posedge clk_in);
    model_step(rst, req, we, addr[4:2], wd);
    #1;
    chk("ack", {31'd0, bus.ack_out}, {31'd0, e_ack});
    chk("rdata", bus.rdata_out, e_rd);
    chk("irq", {31'd0, irq_out}, {31'd0, e_irq});
    last_rd = bus.rdata_out;
    reset_in   = 1'b0;
    bus.req_in = 1'b0;
    bus.we_in  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    cyc(1'b0, 1'b1, 1'b1, addr, wd);
  endtask

  task automatic rdreg(input logic [31:0] addr);
    cyc(1'b0, 1'b1, 1'b0, addr, 32'd0);
  endtask

  initial begin
    reset_in = 1'b1;
    bus.req_in = 1'b0; bus.we_in = 1'b0; bus.addr_in = '0; bus.wdata_in = '0;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
    chk("rst_ack", {31'd0, bus.ack_out}, 32'd0);

    // 1: prescale 3, 40 clocks -> 10 ticks
    wr(32'h14, 32'd3);
    idle(40);
    rdreg(32'h00);
    chk("t1_lo", last_rd, 32'd10);
    rdreg(32'h04);
    chk("t1_hi", last_rd, 32'd0);
    rdreg(32'h10);
    chk("t1_ctrl", last_rd, 32'd1);

    // 2: compare at 5 raises irq, moving compare up drops it
    wr(32'h10, 32'd3);
    wr(32'h14, 32'd0);
    wr(32'h00, 32'd0);
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'd5);
    for (int i = 0; i < 20 && !irq_out; i++) idle(1);
    chk("t2_irq_rise", {31'd0, irq_out}, 32'd1);
    wr(32'h08, 32'd100);
    idle(1);
    chk("t2_irq_drop", {31'd0, irq_out}, 32'd0);

    // 3: mtime write on a tick cycle wins, then freeze
    wr(32'h00, 32'h1234);
    idle(5);
    rdreg(32'h00);
    chk("t3_lo", last_rd, 32'h1234 + 32'd5);
    wr(32'h10, 32'd0);
    rdreg(32'h00);
    frozen = last_rd;
    idle(50);
    rdreg(32'h00);
    chk("t3_frozen", last_rd, frozen);

    // 4: carry into HI and 64-bit wrap
    wr(32'h10, 32'd1);
    wr(32'h04, 32'd0);
    wr(32'h00, 32'hFFFF_FFFF);
    idle(1);
    rdreg(32'h00);
    chk("t4_carry_lo", last_rd, 32'd0);
    rdreg(32'h04);
    chk("t4_carry_hi", last_rd, 32'd1);
    wr(32'h04, 32'hFFFF_FFFF);
    wr(32'h00, 32'hFFFF_FFFF);
    idle(1);
    rdreg(32'h00);
    chk("t4_wrap_lo", last_rd, 32'd0);
    rdreg(32'h04);
    chk("t4_wrap_hi", last_rd, 32'd0);

    // 5: unmapped addresses, back to back
    wr(32'h10, 32'd0);
    rdreg(32'h18);
    chk("t5_rd18", last_rd, 32'd0);
    rdreg(32'h1C);
    chk("t5_rd1c", last_rd, 32'd0);
    wr(32'h18, 32'hDEAD_BEEF);
    chk("t5_wr_ack", {31'd0, bus.ack_out}, 32'd1);
    rdreg(32'h14);
    chk("t5_pre_kept", last_rd, 32'd0);

    // 6: reset right after a request
    rdreg(32'h00);
    cyc(1'b1, 1'b1, 1'b0, 32'h00, 32'd0);
    chk("t6_ack", {31'd0, bus.ack_out}, 32'd0);
    chk("t6_irq", {31'd0, irq_out}, 32'd0);
    rdreg(32'h00);
    chk("t6_mtime", last_rd, 32'd0);
    rdreg(32'h08);
    chk("t6_cmp_lo", last_rd, 32'hFFFF_FFFF);

    // HI read after LO read across a carry
    wr(32'h14, 32'd0);
    wr(32'h04, 32'd0);
    wr(32'h00, 32'hFFFF_FFF0);
    rdreg(32'h00);
    chk("t6_lo", last_rd, 32'hFFFF_FFF0);
    idle(20);
    rdreg(32'h04);
`ifdef MTIMER_HI_LATCH_EN
    chk("t6_hi_latched", last_rd, 32'd0);
`else
    chk("t6_hi_live", last_rd, 32'd1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [31:0] ra, rw;
      logic [2:0]  a;
      a  = 3'($urandom_range(0, 7));
      ra = $urandom;
      ra[4:2] = a;
      rw = $urandom;
      if (a == 3'd5) rw = $urandom_range(0, 3);
      if ((a == 3'd2 || a == 3'd0) && $urandom_range(0, 1) == 1) rw = $urandom_range(0, 40);
      if (a == 3'd3 || a == 3'd1) rw = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, ra, rw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
